// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: show-ahead receive FIFO for a UART receiver.
// Each entry is a character, masked to DATA_BITS, plus a frame-error tag.
// If the FIFO is full, a push without a matching pop is dropped and the
// sticky overrun flag is raised.
module uart_rx_fifo #(
    parameter int DATA_BITS = 7,
    parameter int DEPTH     = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [7:0]                 char_i,
    input  logic                       valid_i,
    input  logic                       frame_error_i,
    input  logic                       ready_i,
    output logic [7:0]                 data_o,
    output logic                       ferr_o,
    output logic                       valid_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       overrun_o,
    input  logic                       clr_overrun_i
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int ENT_W = DATA_BITS + 1;   // {ferr, char}

    // Storage is never reset. Discarding entries only needs the pointers
    // and the count cleared.
    logic [ENT_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overrun_q, overrun_d;

    logic             push_req;
    logic             pop_en;
    logic             push_en;
    logic             full;
    logic             drop;
    logic [ENT_W-1:0] wr_entry;
    logic [ENT_W-1:0] head_entry;

    // A single push happens when either strobe is high. A frame error wins
    // the tag, so valid_i together with frame_error_i gives one entry with ferr=1.
    assign push_req = valid_i | frame_error_i;
    assign full     = (count_q == CNT_W'(DEPTH));
    assign pop_en   = valid_o & ready_i;
    // When the FIFO is full, a push is accepted only if a pop frees the head slot
    // on the same edge.
    assign push_en  = push_req & (~full | pop_en);
    assign drop     = push_req & full & ~pop_en;
    assign wr_entry = {frame_error_i, char_i[DATA_BITS-1:0]};

    // Next-state logic for the pointers, the occupancy count and the sticky overrun flag
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;

        if (push_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        if (push_en && !pop_en) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_en && !push_en) begin
            count_d = count_q - CNT_W'(1);
        end

        // If a drop and a clear occur on the same edge, the drop wins and the flag stays set.
        if (drop) begin
            overrun_d = 1'b1;
        end else if (clr_overrun_i) begin
            overrun_d = 1'b0;
        end
    end

    // Control state register with asynchronous reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    // Storage write. Gating on rst_ni blocks writes while reset is asserted.
    always_ff @(posedge clk_i) begin
        if (push_en && rst_ni) begin
            mem[wr_ptr_q] <= wr_entry;
        end
    end

    // Show-ahead read: the head entry comes straight from storage and is
    // forced to zero when the FIFO is empty
    always_comb begin
        head_entry = '0;
        if (valid_o) begin
            head_entry = mem[rd_ptr_q];
        end
    end

    assign valid_o   = (count_q != '0);
    assign data_o    = 8'(head_entry[DATA_BITS-1:0]);
    assign ferr_o    = head_entry[DATA_BITS];
    assign count_o   = count_q;
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo with DATA_BITS=7 and DEPTH=8.
module tb_uart_rx_fifo;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [7:0] char_i;
    logic       valid_i;
    logic       frame_error_i;
    logic       ready_i;
    logic [7:0] data_o;
    logic       ferr_o;
    logic       valid_o;
    logic [3:0] count_o;
    logic       overrun_o;
    logic       clr_overrun_i;

    int n_checks = 0;
    int n_fail   = 0;

    uart_rx_fifo #(.DATA_BITS(7), .DEPTH(8)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .char_i        (char_i),
        .valid_i       (valid_i),
        .frame_error_i (frame_error_i),
        .ready_i       (ready_i),
        .data_o        (data_o),
        .ferr_o        (ferr_o),
        .valid_o       (valid_o),
        .count_o       (count_o),
        .overrun_o     (overrun_o),
        .clr_overrun_i (clr_overrun_i)
    );

    always #5 clk_i = ~clk_i;

    // Advance one rising edge and settle 1 time unit after it.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        valid_i = 0; frame_error_i = 0; ready_i = 0; clr_overrun_i = 0;
    endtask

    task automatic push(input logic [7:0] c);
        char_i = c; valid_i = 1;
        step();
        valid_i = 0;
    endtask

    task automatic test_reset();
        rst_ni = 0; char_i = 0; idle();
        #2;
        n_checks++;
        if (valid_o !== 1'b0 || count_o !== 4'd0 || data_o !== 8'h00 ||
            ferr_o !== 1'b0 || overrun_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b count=%0d data=%h ferr=%b ovr=%b expected all 0",
                     valid_o, count_o, data_o, ferr_o, overrun_o);
        end
        step(); step();
        rst_ni = 1;
        step();
        $display("reset: count=%0d valid=%b", count_o, valid_o);
    endtask

    task automatic test_basic();
        push(8'h41);
        n_checks++;
        if (valid_o !== 1'b1 || data_o !== 8'h41 || ferr_o !== 1'b0 || count_o !== 4'd1) begin
            n_fail++;
            $display("FAIL basic_push: valid=%b data=%h ferr=%b count=%0d expected 1/41/0/1",
                     valid_o, data_o, ferr_o, count_o);
        end
        ready_i = 1; step(); ready_i = 0;
        n_checks++;
        if (valid_o !== 1'b0 || count_o !== 4'd0 || data_o !== 8'h00) begin
            n_fail++;
            $display("FAIL basic_pop: valid=%b count=%0d data=%h expected 0/0/00",
                     valid_o, count_o, data_o);
        end
        $display("basic: push 41 / pop done");
    endtask

    task automatic test_mask_ferr();
        char_i = 8'hC1; frame_error_i = 1; step(); frame_error_i = 0;
        n_checks++;
        if (data_o !== 8'h41 || ferr_o !== 1'b1 || count_o !== 4'd1) begin
            n_fail++;
            $display("FAIL mask_ferr: data=%h ferr=%b count=%0d expected 41/1/1",
                     data_o, ferr_o, count_o);
        end
        // Both strobes: one entry tagged ferr
        char_i = 8'hFF; valid_i = 1; frame_error_i = 1; step(); idle();
        n_checks++;
        if (count_o !== 4'd2) begin
            n_fail++;
            $display("FAIL both_strobes_count: count=%0d expected 2", count_o);
        end
        ready_i = 1; step(); ready_i = 0;
        n_checks++;
        if (data_o !== 8'h7F || ferr_o !== 1'b1 || count_o !== 4'd1) begin
            n_fail++;
            $display("FAIL both_strobes_entry: data=%h ferr=%b count=%0d expected 7F/1/1",
                     data_o, ferr_o, count_o);
        end
        ready_i = 1; step(); step(); ready_i = 0;   // second pop hits an empty FIFO
        n_checks++;
        if (count_o !== 4'd0 || valid_o !== 1'b0 || ferr_o !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_when_empty: count=%0d valid=%b ferr=%b expected 0/0/0",
                     count_o, valid_o, ferr_o);
        end
        $display("mask_ferr: done");
    endtask

    task automatic test_overrun();
        for (int i = 0; i < 8; i++) push(8'(i));
        n_checks++;
        if (count_o !== 4'd8 || overrun_o !== 1'b0) begin
            n_fail++;
            $display("FAIL fill: count=%0d ovr=%b expected 8/0", count_o, overrun_o);
        end
        push(8'h08);
        n_checks++;
        if (count_o !== 4'd8 || overrun_o !== 1'b1) begin
            n_fail++;
            $display("FAIL drop: count=%0d ovr=%b expected 8/1", count_o, overrun_o);
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (valid_o !== 1'b1 || data_o !== 8'(i)) begin
                n_fail++;
                $display("FAIL drain[%0d]: valid=%b data=%h expected 1/%h", i, valid_o, data_o, 8'(i));
            end
            ready_i = 1; step(); ready_i = 0;
        end
        n_checks++;
        if (valid_o !== 1'b0 || overrun_o !== 1'b1) begin
            n_fail++;
            $display("FAIL drained: valid=%b ovr=%b expected 0/1", valid_o, overrun_o);
        end
        clr_overrun_i = 1; step(); clr_overrun_i = 0;
        n_checks++;
        if (overrun_o !== 1'b0) begin
            n_fail++;
            $display("FAIL clr: ovr=%b expected 0", overrun_o);
        end
        $display("overrun: fill/drop/drain done");
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp_q [$];
        for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
        char_i = 8'h55; valid_i = 1; ready_i = 1; step(); idle();
        n_checks++;
        if (count_o !== 4'd8 || overrun_o !== 1'b0 || data_o !== 8'h11) begin
            n_fail++;
            $display("FAIL full_push_pop: count=%0d ovr=%b head=%h expected 8/0/11",
                     count_o, overrun_o, data_o);
        end
        exp_q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h55};
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (data_o !== exp_q[i]) begin
                n_fail++;
                $display("FAIL full_drain[%0d]: data=%h expected %h", i, data_o, exp_q[i]);
            end
            ready_i = 1; step(); ready_i = 0;
        end
        $display("full_push_pop: done");
    endtask

    task automatic test_clr_set_wins();
        for (int i = 0; i < 8; i++) push(8'h20 + 8'(i));
        push(8'h30);
        char_i = 8'h31; valid_i = 1; clr_overrun_i = 1; step(); idle();
        n_checks++;
        if (overrun_o !== 1'b1 || count_o !== 4'd8) begin
            n_fail++;
            $display("FAIL set_wins: ovr=%b count=%0d expected 1/8", overrun_o, count_o);
        end
        clr_overrun_i = 1; step(); clr_overrun_i = 0;
        n_checks++;
        if (overrun_o !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_only: ovr=%b expected 0", overrun_o);
        end
        ready_i = 1; for (int i = 0; i < 8; i++) step(); ready_i = 0;
        $display("clr_set_wins: done");
    endtask

    task automatic test_empty_push_pop();
        char_i = 8'h2A; valid_i = 1; ready_i = 1; step(); idle();
        n_checks++;
        if (count_o !== 4'd1 || data_o !== 8'h2A) begin
            n_fail++;
            $display("FAIL empty_push_pop: count=%0d data=%h expected 1/2A", count_o, data_o);
        end
        ready_i = 1; step(); ready_i = 0;
        $display("empty_push_pop: done");
    endtask

    task automatic test_async_reset();
        push(8'h01); push(8'h02); push(8'h03);
        #2 rst_ni = 0;
        #1;
        n_checks++;
        if (valid_o !== 1'b0 || count_o !== 4'd0 || data_o !== 8'h00) begin
            n_fail++;
            $display("FAIL async_reset: valid=%b count=%0d data=%h expected 0/0/00",
                     valid_o, count_o, data_o);
        end
        char_i = 8'h44; valid_i = 1; ready_i = 1; step(); idle();
        n_checks++;
        if (count_o !== 4'd0) begin
            n_fail++;
            $display("FAIL push_in_reset: count=%0d expected 0", count_o);
        end
        rst_ni = 1;
        step();
        push(8'h33);
        n_checks++;
        if (count_o !== 4'd1 || data_o !== 8'h33 || valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL after_reset: count=%0d data=%h valid=%b expected 1/33/1",
                     count_o, data_o, valid_o);
        end
        $display("async_reset: done");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mask_ferr();
        test_overrun();
        test_full_push_pop();
        test_clr_set_wins();
        test_empty_push_pop();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DATA_BITS, default 7: number of meaningful character bits; legal range 5..8.
REQ-002 Parameter DEPTH, default 8: number of FIFO entries; power of two, legal range 2..64.
REQ-003 Port clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-004 Port rst_ni  input  1  reset, asynchronous assertion, active-low; synchronous deassertion is provided by the system.
REQ-005 Port char_i  input  8  received character from character_recovery; bits above DATA_BITS-1 are ignored.
REQ-006 Port valid_i  input  1  single-cycle strobe: char_i holds a well-framed character.
REQ-007 Port frame_error_i  input  1  single-cycle strobe: a character ended with a bad stop bit.
REQ-008 Port ready_i  input  1  consumer accepts the head entry this cycle.
REQ-009 Port data_o  output  8  head entry character; bits above DATA_BITS-1 are 0.
REQ-010 Port ferr_o  output  1  head entry was received with a frame error.
REQ-011 Port valid_o  output  1  FIFO is non-empty; data_o and ferr_o are meaningful.
REQ-012 Port count_o  output  $clog2(DEPTH+1)  number of stored entries.
REQ-013 Port overrun_o  output  1  sticky flag: at least one incoming character was dropped.
REQ-014 Port clr_overrun_i  input  1  clears overrun_o.

Function
REQ-015 Push request = valid_i OR frame_error_i; the stored entry is {ferr = frame_error_i, char = char_i masked to DATA_BITS}.
REQ-016 If valid_i and frame_error_i are both high, exactly one entry with ferr=1 is pushed.
REQ-017 Pop = valid_o AND ready_i; ready_i while valid_o=0 has no effect.
REQ-018 Show-ahead: data_o/ferr_o present the oldest entry combinationally from storage whenever valid_o=1; no read latency.
REQ-019 Push-to-visibility latency: an entry pushed into an empty FIFO at edge N is on data_o with valid_o=1 after edge N.
REQ-020 valid_o = (count_o != 0); count_o increments on push-only, decrements on pop-only, unchanged on push+pop or neither.
REQ-021 Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH without a gap.
REQ-022 Full (count_o == DEPTH) with push and no pop: incoming entry dropped, storage and count unchanged, overrun_o set at the next edge.
REQ-023 Full with simultaneous push and pop: both performed, count stays DEPTH, overrun_o unchanged.
REQ-024 Empty with simultaneous push and pop request: pop ignored (valid_o=0), push performed, count becomes 1.
REQ-025 overrun_o stays set until clr_overrun_i is high at an edge; if clr_overrun_i and a new drop occur on the same edge, overrun_o is 1 (set wins).
REQ-026 data_o and ferr_o are 0 whenever valid_o=0.
REQ-027 Entry order is strictly FIFO; no entry is duplicated, reordered or lost except per REQ-022.

Reset
REQ-028 While rst_ni=0: count_o=0, valid_o=0, data_o=0, ferr_o=0, overrun_o=0, both pointers 0, immediately and without a clock.
REQ-029 Reset asserted mid-operation discards all stored entries; storage contents need not be cleared.
REQ-030 Push and pop requests arriving while rst_ni=0 are ignored.

Verification
REQ-031 Reset, push 0x41 via valid_i -> next cycle valid_o=1, data_o=0x41, ferr_o=0, count_o=1; ready_i=1 one cycle -> valid_o=0, count_o=0.
REQ-032 DATA_BITS=7, push char_i=0xC1 with frame_error_i=1 -> data_o=0x41, ferr_o=1.
REQ-033 DEPTH=8, push 0x00..0x07 with ready_i=0, then push 0x08 -> count_o=8, overrun_o=1, drain yields exactly 0x00..0x07 in order.
REQ-034 Full FIFO, push 0x55 with ready_i=1 same cycle -> count_o stays 8, overrun_o stays 0, 0x55 emerges last.
REQ-035 overrun_o=1, clr_overrun_i=1 coincident with another full-drop -> overrun_o=1; next cycle clr only -> overrun_o=0.
REQ-036 Three entries stored, pull rst_ni low between edges -> valid_o=0, count_o=0 before the next edge; after release first push appears alone at head.
